pulse_blinker: RTL and testbench
================================

// Module: pulse_blinker
// PURPOSE
//  Turns single-cycle event pulses (e.g. debouncer o_pulse) back into human-visible
//  LED blinks: each accepted event gives one ON window, then a mandatory OFF gap.
//  Events arriving while a blink is in progress are queued in a saturating counter
//  and replayed as separate blinks. Sits between button/game logic and board LEDs.
// PARAMETERS
//  ON_CYCLES     6000000 (SYNTHESIS) / 500 (sim)  cycles o_led is active per blink (>=1)
//  OFF_CYCLES    6000000 (SYNTHESIS) / 500 (sim)  cycles o_led is inactive between blinks (>=1)
//  MAX_PENDING   15      max queued events; further events while full are dropped
//  ACTIVE_LEVEL  1       value of o_led when lit
//  CBITS         $clog2(max(ON_CYCLES,OFF_CYCLES)+1)  derived, width of phase counter
//  PBITS         $clog2(MAX_PENDING+1)                derived, width of pending count
// PORTS
//  clk         in   1      clock, all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  i_pulse     in   1      event strobe; every cycle sampled high = one event
//  o_led       out  1      blink output, registered
//  o_busy      out  1      1 when state != IDLE, registered
//  o_pending   out  PBITS  queued events not yet blinked, registered
//  o_overflow  out  1      only with PULSE_BLINKER_OVF_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, o_pending=0, o_led=~ACTIVE_LEVEL, o_busy=0,
//    o_overflow=0. Reset mid-blink aborts at once; o_led inactive on the next edge.
//  - States IDLE, ON, GAP; 3-state FSM with one phase counter reset on each entry.
//  - IDLE: i_pulse=1 at edge k -> ON from edge k; o_led active after edge k (1-cycle
//    latency), pending not incremented. Otherwise stay IDLE.
//  - ON: o_led=ACTIVE_LEVEL for exactly ON_CYCLES cycles, then GAP.
//  - GAP: o_led inactive for exactly OFF_CYCLES cycles. On last GAP cycle:
//    pending>0 or i_pulse=1 -> ON directly (no IDLE cycle between blinks);
//    else -> IDLE.
//  - Pending update while in ON/GAP (per cycle): +1 if i_pulse, -1 if a queued event
//    is consumed at GAP end. Last GAP cycle with i_pulse=1 and pending=0: pulse
//    consumed directly, pending stays 0. Pulse + consume with pending>0: unchanged.
//  - Saturation: pending==MAX_PENDING and i_pulse with no consume -> event dropped,
//    pending stays MAX_PENDING. Never wraps.
//  - Blinks emitted = 1 + min(events during busy, MAX_PENDING) (+ consumes freeing room).
//  - o_busy=0 only in IDLE; o_pending=0 whenever o_busy=0.
//  - Counters compare against ON_CYCLES-1 / OFF_CYCLES-1; no other arithmetic.
// CONFIGURATION
//  - PULSE_BLINKER_OVF_EN defined: port o_overflow exists; set to 1 on the edge an
//    event is dropped due to saturation; sticky until rst.
//  - Not defined: port absent, drops are silent; all other behaviour identical.
// TESTING  (ON_CYCLES=4, OFF_CYCLES=3, MAX_PENDING=3, ACTIVE_LEVEL=1 unless noted)
//  - rst, then 1-cycle i_pulse at edge k -> o_led=1 after edges k..k+3, 0 after k+4..,
//    o_busy=1 for 7 cycles, back to IDLE, o_pending=0 throughout.
//  - 3 back-to-back pulses -> o_pending 0,1,2, then 3 blinks 4-on/3-off, no IDLE gap,
//    o_pending decrements at each GAP end, o_busy drops after 21 cycles.
//  - 6 pulses during first ON -> o_pending saturates at 3, 4 blinks total;
//    with PULSE_BLINKER_OVF_EN o_overflow=1 after 5th pulse, held until rst.
//  - Pulse on final GAP cycle with pending=0 -> next ON starts immediately, pending 0.
//  - rst asserted in 2nd ON cycle with pending=2 -> next cycle o_led=0, o_busy=0,
//    o_pending=0; no further blinks.
//  - ACTIVE_LEVEL=0, single pulse -> o_led idles 1, low for 4 cycles, then 1.

Source files
------------

// File: rtl/pulse_blinker.sv
// Stretches single-cycle event pulses into visible LED blinks (ON window + OFF gap),
// queueing events that arrive mid-blink. Optional sticky drop flag: PULSE_BLINKER_OVF_EN.
module pulse_blinker #(
`ifdef SYNTHESIS
  parameter int ON_CYCLES  = 6000000,
  parameter int OFF_CYCLES = 6000000,
`else
  parameter int ON_CYCLES  = 500,
  parameter int OFF_CYCLES = 500,
`endif
  parameter int   MAX_PENDING  = 15,
  parameter logic ACTIVE_LEVEL = 1'b1,
  localparam int  CMAX  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES,
  localparam int  CBITS = $clog2(CMAX + 1),
  localparam int  PBITS = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pulse,
  output logic             o_led,
  output logic             o_busy,
  output logic [PBITS-1:0] o_pending
`ifdef PULSE_BLINKER_OVF_EN
  ,
  output logic             o_overflow
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state_r, state_s;
  logic [CBITS-1:0] cnt_r, cnt_s;
  logic [PBITS-1:0] pending_r, pending_s;
  logic             led_r, busy_r;
  logic             on_last_s, gap_last_s, have_pend_s, full_s;
  logic             queue_s, consume_s;

  // Next-state, phase counter and queue-request decode
  always_comb begin
    on_last_s   = (cnt_r == CBITS'(ON_CYCLES - 1));
    gap_last_s  = (cnt_r == CBITS'(OFF_CYCLES - 1));
    have_pend_s = (pending_r != {PBITS{1'b0}});
    full_s      = (pending_r == PBITS'(MAX_PENDING));
    state_s     = state_r;
    cnt_s       = cnt_r + CBITS'(1);
    queue_s     = 1'b0;
    consume_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_s = {CBITS{1'b0}};
        if (i_pulse) begin
          state_s = S_ON;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ON: begin
        queue_s = i_pulse;
        if (on_last_s) begin
          state_s = S_GAP;
          cnt_s   = {CBITS{1'b0}};
        end else begin
          state_s = S_ON;
        end
      end
      S_GAP: begin
        if (gap_last_s) begin
          cnt_s = {CBITS{1'b0}};
          if (have_pend_s) begin
            // Replay a queued event; a simultaneous pulse takes its slot in the queue.
            consume_s = 1'b1;
            queue_s   = i_pulse;
            state_s   = S_ON;
          end else if (i_pulse) begin
            state_s = S_ON;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          queue_s = i_pulse;
          state_s = S_GAP;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = {CBITS{1'b0}};
      end
    endcase
  end

  // Saturating pending-count update
  always_comb begin
    pending_s = pending_r;
    if (queue_s && !consume_s) begin
      if (!full_s) begin
        pending_s = pending_r + PBITS'(1);
      end else begin
        pending_s = pending_r;
      end
    end else if (consume_s && !queue_s) begin
      pending_s = pending_r - PBITS'(1);
    end else begin
      pending_s = pending_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CBITS{1'b0}};
      pending_r <= {PBITS{1'b0}};
      led_r     <= ~ACTIVE_LEVEL;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pending_r <= pending_s;
      led_r     <= (state_s == S_ON) ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
      busy_r    <= (state_s != S_IDLE);
    end
  end

  assign o_led     = led_r;
  assign o_busy    = busy_r;
  assign o_pending = pending_r;

`ifdef PULSE_BLINKER_OVF_EN
  logic ovf_r;
  logic drop_s;

  assign drop_s = queue_s && !consume_s && full_s;

  // Sticky record of any event lost to saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | drop_s;
    end
  end

  assign o_overflow = ovf_r;
`endif

endmodule

// File: tb/tb_pulse_blinker.sv
// Scoreboard bench for pulse_blinker (ON=4, OFF=3, MAX_PENDING=3), with a second
// instance at ACTIVE_LEVEL=0 sharing the same stimulus.
module tb_pulse_blinker;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int MAXP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_pulse = 1'b0;
  logic       led, busy, lo_led, lo_busy;
  logic [1:0] pend, lo_pend;
`ifdef PULSE_BLINKER_OVF_EN
  logic       ovf, lo_ovf;
`endif

  always #5 clk = ~clk;

  pulse_blinker #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_PENDING(MAXP), .ACTIVE_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .i_pulse(i_pulse),
    .o_led(led), .o_busy(busy), .o_pending(pend)
`ifdef PULSE_BLINKER_OVF_EN
    , .o_overflow(ovf)
`endif
  );

  pulse_blinker #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_PENDING(MAXP), .ACTIVE_LEVEL(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .i_pulse(i_pulse),
    .o_led(lo_led), .o_busy(lo_busy), .o_pending(lo_pend)
`ifdef PULSE_BLINKER_OVF_EN
    , .o_overflow(lo_ovf)
`endif
  );

  typedef struct {
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
    logic       lo_led;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference: cycles left in the current blink (ON+OFF .. 1, 0 = idle)
  int   m_rem = 0;
  int   m_pend = 0;
  logic m_ovf = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic p, input logic r);
    exp_t e;
    if (r) begin
      m_rem = 0; m_pend = 0; m_ovf = 1'b0;
    end else if (m_rem == 0) begin
      if (p) m_rem = ON + OFF;
    end else if (m_rem == 1) begin
      if (m_pend > 0) begin
        if (!p) m_pend--;
        m_rem = ON + OFF;
      end else if (p) begin
        m_rem = ON + OFF;
      end else begin
        m_rem = 0;
      end
    end else begin
      m_rem--;
      if (p) begin
        if (m_pend < MAXP) m_pend++;
        else m_ovf = 1'b1;
      end
    end
    e.led    = (m_rem > OFF);
    e.busy   = (m_rem != 0);
    e.pend   = m_pend[1:0];
    e.ovf    = m_ovf;
    e.lo_led = !(m_rem > OFF);
    sb_q.push_back(e);
  endtask

  task automatic step(input logic p, input logic r);
    exp_t e;
    @(negedge clk);
    i_pulse = p;
    rst     = r;
    model_edge(p, r);
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val("led", {31'd0, led}, {31'd0, e.led});
      check_val("busy", {31'd0, busy}, {31'd0, e.busy});
      check_val("pending", {30'd0, pend}, {30'd0, e.pend});
      check_val("led_lo", {31'd0, lo_led}, {31'd0, e.lo_led});
      check_val("busy_lo", {31'd0, lo_busy}, {31'd0, e.busy});
`ifdef PULSE_BLINKER_OVF_EN
      check_val("overflow", {31'd0, ovf}, {31'd0, e.ovf});
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    // reset state
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    idle(3);
    // single blink
    pulses(1);
    idle(10);
    // three back-to-back events, replayed without idle gaps
    pulses(3);
    idle(25);
    // saturation: seven events, first starts, three queue, rest dropped
    pulses(7);
    idle(40);
    step(1'b0, 1'b1);
    idle(2);
    // pulse on final GAP cycle with nothing pending
    pulses(1);
    idle(6);
    pulses(1);
    idle(10);
    // pulse on final GAP cycle with one pending
    pulses(2);
    idle(5);
    pulses(1);
    idle(20);
    // reset mid-blink with pending events aborts everything
    pulses(3);
    step(1'b0, 1'b1);
    idle(15);
    // saturation then a long quiet stretch, overflow must persist until reset
    pulses(8);
    idle(12);
    pulses(2);
    idle(30);
    step(1'b0, 1'b1);
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
